// File: rtl/ula_sequencer.sv
// Issue/writeback controller for the external combinational ULA: it accepts instructions,
// drives registered operands, and writes results back to a 4-entry register file and Z/C flags.
module ula_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [3:0]         instr_op,
   input  logic [1:0]         instr_rd,
   input  logic [1:0]         instr_ra,
   input  logic [1:0]         instr_rb,
   input  logic [WIDTH-1:0]   instr_imm,
   input  logic               instr_use_imm,
   input  logic               instr_cin_en,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [3:0]         alu_op,
   output logic               alu_cin,
   input  logic [2*WIDTH-1:0] alu_s,
   input  logic               alu_cout,
   output logic               res_valid,
   output logic [1:0]         res_rd,
   output logic [WIDTH-1:0]   res_data,
   output logic               flag_z,
   output logic               flag_c,
   output logic               err_div0,
   input  logic [1:0]         dbg_sel,
   output logic [WIDTH-1:0]   dbg_data
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_INC = 4'd4;
   localparam logic [3:0] OP_DEC = 4'd5;
   localparam logic [3:0] OP_CMP = 4'd6;
   localparam logic [3:0] OP_SHL = 4'd11;
   localparam logic [3:0] OP_LDI = 4'd15;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB_HI} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_regs [4];
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [3:0]       r_alu_op;
   logic             r_alu_cin;
   logic [1:0]       r_rd;
   logic [WIDTH-1:0] r_imm;
   logic             r_res_valid;
   logic [1:0]       r_res_rd;
   logic [WIDTH-1:0] r_res_data;
   logic             r_flag_z;
   logic             r_flag_c;
   logic             r_err_div0;

   logic             w_accept;
   logic             w_we;
   logic [1:0]       w_wr_idx;
   logic [WIDTH-1:0] w_wr_data;
   logic             w_z_we;
   logic             w_z_nxt;
   logic             w_c_we;
   logic             w_c_nxt;
   logic             w_div0_set;

   assign w_accept = (r_state == ST_IDLE) && instr_valid;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_wr_idx    = r_rd;
      w_wr_data   = alu_s[WIDTH-1:0];
      w_z_we      = 1'b0;
      w_z_nxt     = 1'b0;
      w_c_we      = 1'b0;
      w_c_nxt     = 1'b0;
      w_div0_set  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (instr_valid) w_state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            w_state_nxt = ST_IDLE;
            if (r_alu_op == OP_LDI) begin
               w_we      = 1'b1;
               w_wr_data = r_imm;
               w_z_we    = 1'b1;
               w_z_nxt   = (r_imm == '0);
            end else if (r_alu_op == OP_CMP) begin
               w_z_we  = 1'b1;
               w_z_nxt = alu_s[0];
            end else if (r_alu_op == OP_DIV && r_alu_b == '0) begin
               w_div0_set = 1'b1;
            end else if (r_alu_op == OP_MUL || r_alu_op == OP_DIV) begin
               w_we        = 1'b1;
               w_state_nxt = ST_WB_HI;
            end else begin
               w_we    = 1'b1;
               w_z_we  = 1'b1;
               w_z_nxt = (alu_s[WIDTH-1:0] == '0);
               w_c_we  = r_alu_op inside {OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_SHL};
               w_c_nxt = alu_cout;
            end
         end
         ST_WB_HI: begin
            // High half goes to the next register; the 2-bit index wraps R3 -> R0.
            w_state_nxt = ST_IDLE;
            w_we        = 1'b1;
            w_wr_idx    = r_rd + 2'd1;
            w_wr_data   = alu_s[2*WIDTH-1:WIDTH];
            w_z_we      = 1'b1;
            w_z_nxt     = (alu_s == '0);
            w_c_we      = 1'b1;
            w_c_nxt     = 1'b0;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         // NOTE: the register file is architecturally visible and must read zero after reset.
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= '0;
         r_alu_cin   <= 1'b0;
         r_rd        <= '0;
         r_imm       <= '0;
         r_res_valid <= 1'b0;
         r_res_rd    <= '0;
         r_res_data  <= '0;
         r_flag_z    <= 1'b0;
         r_flag_c    <= 1'b0;
         r_err_div0  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_res_valid <= w_we;
         if (w_accept) begin
            r_alu_a   <= r_regs[instr_ra];
            r_alu_b   <= instr_use_imm ? instr_imm : r_regs[instr_rb];
            r_alu_op  <= instr_op;
            r_alu_cin <= (instr_op == OP_ADD && instr_cin_en) ? r_flag_c : 1'b0;
            r_rd      <= instr_rd;
            r_imm     <= instr_imm;
         end
         if (w_we) begin
            r_regs[w_wr_idx] <= w_wr_data;
            r_res_rd         <= w_wr_idx;
            r_res_data       <= w_wr_data;
         end
         if (w_z_we)     r_flag_z   <= w_z_nxt;
         if (w_c_we)     r_flag_c   <= w_c_nxt;
         if (w_div0_set) r_err_div0 <= 1'b1;
      end
   end

   assign instr_ready = (r_state == ST_IDLE);
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_op      = r_alu_op;
   assign alu_cin     = r_alu_cin;
   assign res_valid   = r_res_valid;
   assign res_rd      = r_res_rd;
   assign res_data    = r_res_data;
   assign flag_z      = r_flag_z;
   assign flag_c      = r_flag_c;
   assign err_div0    = r_err_div0;
   assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_ula_sequencer.sv
// Self-checking bench for ula_sequencer: a behavioural ULA drives alu_s/alu_cout, and a
// transaction-level model predicts every output on every cycle.
module tb_ula_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [3:0] instr_op = '0;
   logic [1:0] instr_rd = '0, instr_ra = '0, instr_rb = '0;
   logic [3:0] instr_imm = '0;
   logic       instr_use_imm = 1'b0, instr_cin_en = 1'b0;
   logic [3:0] alu_a, alu_b, alu_op;
   logic       alu_cin;
   logic [7:0] alu_s;
   logic       alu_cout;
   logic       res_valid;
   logic [1:0] res_rd;
   logic [3:0] res_data;
   logic       flag_z, flag_c, err_div0;
   logic [1:0] dbg_sel = '0;
   logic [3:0] dbg_data;

   ula_sequencer #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
      .instr_imm(instr_imm), .instr_use_imm(instr_use_imm), .instr_cin_en(instr_cin_en),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_s(alu_s), .alu_cout(alu_cout),
      .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
      .flag_z(flag_z), .flag_c(flag_c), .err_div0(err_div0),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // Behavioural ULA: returns {cout, s[7:0]}.
   function automatic logic [8:0] ula(input logic [3:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic cin);
      logic [4:0] t;
      logic [7:0] s;
      logic       co;
      t = '0; s = '0; co = 1'b0;
      case (op)
         4'd0:  begin t = {1'b0, a} + {1'b0, b} + {4'b0, cin}; s[3:0] = t[3:0]; co = t[4]; end
         4'd1:  begin t = {1'b0, a} - {1'b0, b}; s[3:0] = t[3:0]; co = t[4]; end
         4'd2:  s = {4'b0, a} * {4'b0, b};
         4'd3:  if (b != 0) s = {a % b, a / b};
         4'd4:  begin t = {1'b0, a} + 5'd1; s[3:0] = t[3:0]; co = t[4]; end
         4'd5:  begin t = {1'b0, a} - 5'd1; s[3:0] = t[3:0]; co = t[4]; end
         4'd6:  s[0] = (a == b);
         4'd7:  s[3:0] = a & b;
         4'd8:  s[3:0] = a | b;
         4'd9:  s[3:0] = a ^ b;
         4'd10: s[3:0] = ~a;
         4'd11: begin s[3:0] = {a[2:0], 1'b0}; co = a[3]; end
         4'd12: begin s[3:0] = {1'b0, a[3:1]}; co = a[0]; end
         4'd13: s[3:0] = {a[2:0], a[3]};
         4'd14: s[3:0] = {a[0], a[3:1]};
         default: s[3:0] = b;
      endcase
      return {co, s};
   endfunction

   assign {alu_cout, alu_s} = ula(alu_op, alu_a, alu_b, alu_cin);

   // ---------------- reference model: per-cycle event timeline ----------------
   typedef struct {
      logic       we;
      logic [1:0] rd;
      logic [3:0] data;
      logic       z_we, z, c_we, c, err;
   } ev_t;

   ev_t        m_q[$];
   logic [3:0] m_regs [4];
   logic       m_z, m_c, m_err;
   logic [3:0] m_a, m_b, m_op;
   logic       m_cin;
   logic       m_rv = 1'b0;
   logic [1:0] m_rd = '0;
   logic [3:0] m_data = '0;
   logic       m_acc = 1'b0;
   int         m_accepts = 0;

   int   n_cmp = 0, n_bad = 0, n_rv = 0;
   logic chk_en = 1'b0;

   function automatic ev_t mk_ev(input logic we, input logic [1:0] rd, input logic [3:0] data,
                                 input logic z_we, input logic z, input logic c_we,
                                 input logic c, input logic err);
      ev_t e;
      e.we = we; e.rd = rd; e.data = data; e.z_we = z_we; e.z = z;
      e.c_we = c_we; e.c = c; e.err = err;
      return e;
   endfunction

   task automatic model_edge();
      ev_t        e;
      logic [8:0] r;
      logic [3:0] b;
      logic       ci;
      logic [1:0] hi_rd;
      m_rv  = 1'b0;
      m_acc = 1'b0;
      if (!rst_n) begin
         m_q.delete();
         for (int i = 0; i < 4; i++) m_regs[i] = '0;
         m_z = 0; m_c = 0; m_err = 0; m_a = 0; m_b = 0; m_op = 0; m_cin = 0;
      end else if (m_q.size() != 0) begin
         e = m_q.pop_front();
         if (e.we) begin m_regs[e.rd] = e.data; m_rv = 1'b1; m_rd = e.rd; m_data = e.data; end
         if (e.z_we) m_z = e.z;
         if (e.c_we) m_c = e.c;
         if (e.err)  m_err = 1'b1;
      end else if (instr_valid) begin
         m_acc = 1'b1;
         m_accepts++;
         b  = instr_use_imm ? instr_imm : m_regs[instr_rb];
         ci = (instr_op == 4'd0 && instr_cin_en) ? m_c : 1'b0;
         m_a = m_regs[instr_ra]; m_b = b; m_op = instr_op; m_cin = ci;
         r = ula(instr_op, m_a, b, ci);
         hi_rd = 2'((int'(instr_rd) + 1) % 4);
         if (instr_op == 4'd15)
            m_q.push_back(mk_ev(1, instr_rd, instr_imm, 1, instr_imm == 0, 0, 0, 0));
         else if (instr_op == 4'd6)
            m_q.push_back(mk_ev(0, 0, 0, 1, r[0], 0, 0, 0));
         else if (instr_op == 4'd3 && b == 0)
            m_q.push_back(mk_ev(0, 0, 0, 0, 0, 0, 0, 1));
         else if (instr_op == 4'd2 || instr_op == 4'd3) begin
            m_q.push_back(mk_ev(1, instr_rd, r[3:0], 0, 0, 0, 0, 0));
            m_q.push_back(mk_ev(1, hi_rd, r[7:4], 1, r[7:0] == 0, 1, 0, 0));
         end else
            m_q.push_back(mk_ev(1, instr_rd, r[3:0], 1, r[3:0] == 0,
                                instr_op inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd11}, r[8], 0));
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_edge();
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("instr_ready", {31'b0, instr_ready}, {31'b0, m_q.size() == 0});
         check("alu_a", {28'b0, alu_a}, {28'b0, m_a});
         check("alu_b", {28'b0, alu_b}, {28'b0, m_b});
         check("alu_op", {28'b0, alu_op}, {28'b0, m_op});
         check("alu_cin", {31'b0, alu_cin}, {31'b0, m_cin});
         check("res_valid", {31'b0, res_valid}, {31'b0, m_rv});
         if (m_rv) begin
            check("res_rd", {30'b0, res_rd}, {30'b0, m_rd});
            check("res_data", {28'b0, res_data}, {28'b0, m_data});
         end
         check("flag_z", {31'b0, flag_z}, {31'b0, m_z});
         check("flag_c", {31'b0, flag_c}, {31'b0, m_c});
         check("err_div0", {31'b0, err_div0}, {31'b0, m_err});
         check("dbg_data", {28'b0, dbg_data}, {28'b0, m_regs[dbg_sel]});
         if (res_valid === 1'b1) n_rv++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [3:0] imm, input logic use_imm,
                        input logic cin_en);
      bit done = 0;
      instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
      instr_imm = imm; instr_use_imm = use_imm; instr_cin_en = cin_en;
      instr_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge clk); #1;
         if (m_acc) done = 1;
      end
      instr_valid = 1'b0;
      if (!done) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && m_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      if (m_q.size() != 0) check("idle_timeout", 0, 1);
      @(negedge clk); #1;
   endtask

   task automatic chk_reg(input string name, input logic [1:0] idx, input logic [3:0] exp);
      dbg_sel = idx;
      #1;
      check(name, {28'b0, dbg_data}, {28'b0, exp});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rv0, acc0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      check("reset_ready", {31'b0, instr_ready}, 1);
      check("reset_err", {31'b0, err_div0}, 0);

      // LDI/LDI/ADD with wraparound: 9 + 7 = 0x10
      rv0 = n_rv;
      issue(4'd15, 2'd0, 0, 0, 4'd9, 0, 0);
      issue(4'd15, 2'd1, 0, 0, 4'd7, 0, 0);
      issue(4'd0, 2'd2, 2'd0, 2'd1, 4'd0, 0, 0);
      wait_idle();
      check("add_alu_a", {28'b0, alu_a}, 9);
      check("add_alu_b", {28'b0, alu_b}, 7);
      check("add_alu_op", {28'b0, alu_op}, 0);
      check("add_z", {31'b0, flag_z}, 1);
      check("add_c", {31'b0, flag_c}, 1);
      chk_reg("add_r2", 2'd2, 4'h0);
      check("add_pulses", n_rv - rv0, 3);

      // MUL rd=3: 9*7 = 0x3F -> R3=F, R0=3 (wrap)
      rv0 = n_rv;
      issue(4'd2, 2'd3, 2'd0, 2'd1, 4'd0, 0, 0);
      wait_idle();
      chk_reg("mul_r3", 2'd3, 4'hF);
      chk_reg("mul_r0", 2'd0, 4'h3);
      check("mul_pulses", n_rv - rv0, 2);
      check("mul_z", {31'b0, flag_z}, 0);
      check("mul_c", {31'b0, flag_c}, 0);

      // DIV by R2 (=0)
      rv0 = n_rv;
      issue(4'd3, 2'd1, 2'd0, 2'd2, 4'd0, 0, 0);
      wait_idle();
      check("div0_err", {31'b0, err_div0}, 1);
      check("div0_pulses", n_rv - rv0, 0);
      chk_reg("div0_r1", 2'd1, 4'h7);
      chk_reg("div0_r3", 2'd3, 4'hF);

      // CMP R0,R0 -> Z=1, C unchanged
      rv0 = n_rv;
      issue(4'd6, 2'd2, 2'd0, 2'd0, 4'd0, 0, 0);
      wait_idle();
      check("cmp_z", {31'b0, flag_z}, 1);
      check("cmp_c", {31'b0, flag_c}, 0);
      check("cmp_pulses", n_rv - rv0, 0);
      chk_reg("cmp_r0", 2'd0, 4'h3);

      // Held valid: ADD R0=R0+1 for 6 edges from R0=0 -> 3 acceptances
      issue(4'd15, 2'd0, 0, 0, 4'd0, 0, 0);
      wait_idle();
      acc0 = m_accepts;
      instr_op = 4'd0; instr_rd = 2'd0; instr_ra = 2'd0; instr_rb = 2'd3;
      instr_imm = 4'd1; instr_use_imm = 1'b1; instr_cin_en = 1'b0;
      instr_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1 instr_valid = 1'b0;
      wait_idle();
      check("hold_accepts", m_accepts - acc0, 3);
      chk_reg("hold_r0", 2'd0, 4'h3);

      // Reset during WB_HI of a MUL
      issue(4'd2, 2'd3, 2'd3, 2'd1, 4'd0, 0, 0);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      check("rst_ready", {31'b0, instr_ready}, 1);
      check("rst_rv", {31'b0, res_valid}, 0);
      check("rst_z", {31'b0, flag_z}, 0);
      check("rst_c", {31'b0, flag_c}, 0);
      check("rst_err", {31'b0, err_div0}, 0);
      for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 4'h0);

      // Randomized traffic with payload changes while stalled and rare resets
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         rst_n         = ($urandom_range(0, 199) != 0);
         instr_valid   = ($urandom_range(0, 9) < 7);
         instr_op      = 4'($urandom_range(0, 15));
         instr_rd      = 2'($urandom_range(0, 3));
         instr_ra      = 2'($urandom_range(0, 3));
         instr_rb      = 2'($urandom_range(0, 3));
         instr_imm     = 4'($urandom_range(0, 15));
         instr_use_imm = 1'($urandom_range(0, 1));
         instr_cin_en  = 1'($urandom_range(0, 1));
         dbg_sel       = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      instr_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
- Multi-cycle issue/writeback controller that sits directly upstream and downstream of the ULA datapath.
- Accepts instruction words over a valid/ready handshake and reads operands from an internal 4-entry register file.
- Drives ULA operands, opcode and carry-in; captures the ULA result and carry-out back into the register file, the Z/C flags and a result strobe.
- The ULA itself stays combinational and external.

Parameters:
- WIDTH, 4, data width of registers, operands and immediate; wide results are 2*WIDTH.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept; high iff state==IDLE
- instr_op  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 INC, 5 DEC, 6 CMP, 7 AND, 8 OR, 9 XOR, 10 NOT, 11 SHL, 12 SHR, 13 ROL, 14 ROR, 15 LDI
- instr_rd  in  2  destination register
- instr_ra  in  2  operand A register
- instr_rb  in  2  operand B register
- instr_imm  in  WIDTH  immediate (LDI value; B operand when instr_use_imm)
- instr_use_imm  in  1  B operand = instr_imm instead of R[rb]
- instr_cin_en  in  1  ADD only: alu_cin = C flag; otherwise alu_cin = 0
- alu_a  out  WIDTH  registered operand A
- alu_b  out  WIDTH  registered operand B
- alu_op  out  4  registered opcode
- alu_cin  out  1  registered carry-in
- alu_s  in  2*WIDTH  ULA result; MUL = full product; DIV = {remainder, quotient}; all other ops use the low WIDTH bits
- alu_cout  in  1  ULA carry/borrow out
- res_valid  out  1  one-cycle pulse on each register write
- res_rd  out  2  register written
- res_data  out  WIDTH  value written
- flag_z  out  1  zero flag
- flag_c  out  1  carry flag
- err_div0  out  1  sticky divide-by-zero; cleared only by reset
- dbg_sel  in  2  debug read select
- dbg_data  out  WIDTH  R[dbg_sel], combinational

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - R0..R3=0, state=IDLE.
  - alu_a/alu_b/alu_op/alu_cin=0; res_valid=0, res_rd=0, res_data=0.
  - flag_z=0, flag_c=0, err_div0=0.
  - Reset overrides any in-flight operation; no write completes.
  - An instruction presented while rst_n=0 is not accepted.
- States: IDLE, EXEC, WB_HI.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&rst_n, latch into the alu_* outputs: A=R[ra], B=use_imm?imm:R[rb], op, cin; also latch rd.
  - Go to EXEC.
- EXEC (one cycle; the ULA settles combinationally):
  - LDI: R[rd]=imm; Z=(imm==0); C unchanged; -> IDLE.
  - CMP: no register write, no res_valid; Z=alu_s[0]; C unchanged; -> IDLE.
  - DIV with alu_b==0: err_div0=1; no write, no flag change; -> IDLE.
  - MUL, or DIV with alu_b!=0: R[rd]=alu_s[WIDTH-1:0]; -> WB_HI.
  - All other ops: R[rd]=alu_s[WIDTH-1:0]; Z=(that value==0); -> IDLE.
    - C=alu_cout for ADD/SUB/INC/DEC/SHL.
    - C unchanged for logic/SHR/rotates.
- WB_HI:
  - R[(rd+1) mod 4]=alu_s[2*WIDTH-1:WIDTH]; index wraps, so rd=3 writes R0.
  - Z=(full 2*WIDTH result==0); C=0; -> IDLE.
- Every register write drives res_valid/res_rd/res_data in the same cycle as the write.
- Latency:
  - Instruction accepted at edge N; the write lands at edge N+1 (N+2 for the WB_HI write).
  - Next acceptance earliest at edge N+2 (N+3 for MUL/DIV).
- Operand hazards: none possible. Operands are latched at accept, so rd==ra/rb and a high-half overwrite of a source register are both safe.
- Handshake:
  - instr_valid held while instr_ready=0 is ignored.
  - A held instruction is accepted exactly once, when ready rises.
  - The source may change payload while not accepted.

Test Plan:
- LDI R0=9, LDI R1=7, ADD R2=R0+R1 (cin_en=0) -> alu_a=9, alu_b=7, alu_op=0; with alu_s=0x00, cout=1: R2=0, Z=1, C=1, res_valid once per instruction.
- MUL rd=3, R0=9, R1=7, ULA returns 0x3F -> R3=F at EXEC, R0=3 at WB_HI (wrap), two res_valid pulses, ready low for 2 cycles.
- DIV with rb register holding 0 -> err_div0=1, all registers and flags unchanged, no res_valid, ready back after 1 busy cycle.
- Hold instr_valid=1 continuously with a fixed ADD R0=R0+imm(1) for 6 cycles from R0=0 -> exactly 3 acceptances, R0=3.
- rst_n=0 during WB_HI of a MUL -> next cycle all registers 0, flags 0, res_valid=0, instr_ready=1.
- CMP R0,R0, ULA returns alu_s=1 -> Z=1, C and all registers unchanged, no res_valid.
